// File: rtl/bpsk_tx_pkg.sv
// Shared state encoding, defaults and frame-length helper for bpsk_tx_sequencer.
// Macro BPSK_TX_CHECKSUM_EN adds the CHECKSUM state and the trailing XOR byte.
package bpsk_tx_pkg;

   localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hD3;

   // Must track PACKET_WIDTH_OVERHEAD from the system parameters.svh.
`ifdef BPSK_TX_CHECKSUM_EN
   localparam int unsigned PACKET_WIDTH_OVERHEAD_DEFAULT = 64;
`else
   localparam int unsigned PACKET_WIDTH_OVERHEAD_DEFAULT = 56;
`endif

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PREAMBLE,
      SYNC,
      PAYLOAD,
`ifdef BPSK_TX_CHECKSUM_EN
      CHECKSUM,
`endif
      WAIT_DONE
   } tx_state_t;

   function automatic int unsigned tx_frame_bits(input int unsigned preamble,
                                                 input int unsigned payload);
      int unsigned bits;
      bits = preamble + 8 + 8 * payload;
`ifdef BPSK_TX_CHECKSUM_EN
      bits = bits + 8;
`endif
      return bits;
   endfunction

endpackage

// File: rtl/tx_bit_serializer.sv
// MSB-first 8-bit serializer; o_bit_out is the bit that will be on the line
// after this cycle's load/shift, so the caller can register it directly.
module tx_bit_serializer (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_load,
   input  logic       i_shift,
   input  logic [7:0] i_data,
   output logic       o_bit_out,
   output logic       o_last_bit
);

   logic [7:0] r_shift;
   logic [2:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_shift <= i_data;
         r_cnt   <= '0;
      end else if (i_shift) begin
         r_shift <= {r_shift[6:0], 1'b0};
         r_cnt   <= r_cnt + 3'd1;
      end
   end

   assign o_bit_out  = i_load ? i_data[7] : (i_shift ? r_shift[6] : r_shift[7]);
   assign o_last_bit = (r_cnt == 3'd7);

endmodule

// File: rtl/bpsk_tx_sequencer.sv
// Frame sequencer feeding signal_modulator: preamble, sync word, payload
// (and a checksum byte when BPSK_TX_CHECKSUM_EN is defined), one bit per mod_next.
module bpsk_tx_sequencer
   import bpsk_tx_pkg::*;
#(
   parameter int unsigned PAYLOAD_BYTES         = 4,
   parameter int unsigned PREAMBLE_BITS         = 16,
   parameter logic [7:0]  SYNC_WORD             = SYNC_WORD_DEFAULT,
   parameter int unsigned PACKET_WIDTH_OVERHEAD = PACKET_WIDTH_OVERHEAD_DEFAULT
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_tx_start,
   input  logic [7:0] i_in_data,
   input  logic       i_in_valid,
   output logic       o_in_ready,
   output logic       o_mod_enable,
   output logic       o_mod_data,
   input  logic       i_mod_next,
   input  logic       i_mod_done,
   output logic       o_busy,
   output logic       o_tx_done,
   output logic       o_underrun
);

   localparam int unsigned FRAME_BITS = tx_frame_bits(PREAMBLE_BITS, PAYLOAD_BYTES);
   localparam int unsigned SYM_W      = $clog2(FRAME_BITS + 1);
   localparam int unsigned BYTE_W     = $clog2(PAYLOAD_BYTES + 1);
   localparam logic [SYM_W-1:0]  LAST_PRE   = SYM_W'(PREAMBLE_BITS - 1);
   localparam logic [BYTE_W-1:0] NUM_BYTES  = BYTE_W'(PAYLOAD_BYTES);

   if (FRAME_BITS != PACKET_WIDTH_OVERHEAD) begin : g_bad_frame_len
      $error("bpsk_tx_sequencer: frame bits %0d != PACKET_WIDTH_OVERHEAD %0d",
             FRAME_BITS, PACKET_WIDTH_OVERHEAD);
   end
   if (PAYLOAD_BYTES < 1 || PREAMBLE_BITS < 2 || (PREAMBLE_BITS % 2) != 0) begin : g_bad_params
      $error("bpsk_tx_sequencer: illegal PAYLOAD_BYTES/PREAMBLE_BITS");
   end

   tx_state_t         r_state;
   logic [SYM_W-1:0]  r_sym_cnt;
   logic [BYTE_W-1:0] r_byte_cnt;
   logic [BYTE_W-1:0] r_fetch_cnt;
   logic [7:0]        r_hold;
   logic              r_hold_valid;
   logic              r_in_ready, r_mod_enable, r_mod_data, r_busy, r_tx_done, r_underrun;
`ifdef BPSK_TX_CHECKSUM_EN
   logic [7:0]        r_csum;
`endif

   logic              w_start, w_adv, w_accept, w_boundary, w_pay_last;
   logic              w_ser_load, w_ser_shift, w_ser_bit, w_ser_last;
   logic              w_hold_valid_nxt, w_fetch_phase_nxt;
   logic [7:0]        w_ser_data, w_pay_byte;
   logic [BYTE_W-1:0] w_fetch_nxt;

   assign w_start    = (r_state == IDLE) && i_tx_start;
   assign w_accept   = i_in_valid && r_in_ready;
   assign w_pay_byte = r_hold_valid ? r_hold : 8'h00;
   assign w_pay_last = (r_byte_cnt == NUM_BYTES);
   assign w_adv      = i_mod_next && (r_state inside {PREAMBLE, SYNC, PAYLOAD
`ifdef BPSK_TX_CHECKSUM_EN
                                                      , CHECKSUM
`endif
                                                      });
   assign w_boundary = i_mod_next && w_ser_last &&
                       ((r_state == SYNC) || (r_state == PAYLOAD && !w_pay_last));

   always_comb begin
      w_ser_load  = 1'b0;
      w_ser_shift = 1'b0;
      w_ser_data  = w_pay_byte;
      if (i_mod_next) begin
         case (r_state)
            PREAMBLE: if (r_sym_cnt == LAST_PRE) begin
               w_ser_load = 1'b1;
               w_ser_data = SYNC_WORD;
            end
            SYNC: if (w_ser_last) w_ser_load = 1'b1;
                  else            w_ser_shift = 1'b1;
            PAYLOAD: if (!w_ser_last)     w_ser_shift = 1'b1;
                     else if (!w_pay_last) w_ser_load = 1'b1;
`ifdef BPSK_TX_CHECKSUM_EN
                     else begin
                        w_ser_load = 1'b1;
                        w_ser_data = r_csum;
                     end
            CHECKSUM: if (!w_ser_last) w_ser_shift = 1'b1;
`endif
            default: ;
         endcase
      end
   end

   // NOTE: in_ready is a register, so it is computed from the next-cycle
   // state, holding flag and fetch count rather than the current ones.
   always_comb begin
      if (w_start)         w_hold_valid_nxt = 1'b0;
      else if (w_accept)   w_hold_valid_nxt = 1'b1;
      else if (w_boundary) w_hold_valid_nxt = 1'b0;
      else                 w_hold_valid_nxt = r_hold_valid;
      w_fetch_nxt = w_start ? '0 : r_fetch_cnt + BYTE_W'(w_accept);
      case (r_state)
         IDLE:                  w_fetch_phase_nxt = w_start;
         LOAD, PREAMBLE, SYNC:  w_fetch_phase_nxt = 1'b1;
         PAYLOAD:               w_fetch_phase_nxt = !(i_mod_next && w_ser_last && w_pay_last);
         default:               w_fetch_phase_nxt = 1'b0;
      endcase
   end

   tx_bit_serializer u_ser (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_ser_load),
      .i_shift    (w_ser_shift),
      .i_data     (w_ser_data),
      .o_bit_out  (w_ser_bit),
      .o_last_bit (w_ser_last)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_sym_cnt    <= '0;
         r_byte_cnt   <= '0;
         r_fetch_cnt  <= '0;
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
         r_in_ready   <= 1'b0;
         r_mod_enable <= 1'b0;
         r_mod_data   <= 1'b0;
         r_busy       <= 1'b0;
         r_tx_done    <= 1'b0;
         r_underrun   <= 1'b0;
`ifdef BPSK_TX_CHECKSUM_EN
         r_csum       <= '0;
`endif
      end else begin
         r_mod_enable <= 1'b0;
         r_tx_done    <= 1'b0;
         r_hold_valid <= w_hold_valid_nxt;
         r_fetch_cnt  <= w_fetch_nxt;
         r_in_ready   <= w_fetch_phase_nxt && !w_hold_valid_nxt && (w_fetch_nxt < NUM_BYTES);
         if (w_accept) r_hold <= i_in_data;
         if (w_adv)    r_sym_cnt <= r_sym_cnt + SYM_W'(1);
         if (w_ser_load || w_ser_shift) r_mod_data <= w_ser_bit;
         // A missing byte is replaced by 0x00: the modulator cannot be paused.
         if (w_boundary) begin
            r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
            if (!r_hold_valid) r_underrun <= 1'b1;
`ifdef BPSK_TX_CHECKSUM_EN
            r_csum <= r_csum ^ w_pay_byte;
`endif
         end

         case (r_state)
            IDLE: if (i_tx_start) begin
               r_state      <= LOAD;
               r_mod_enable <= 1'b1;
               r_mod_data   <= 1'b1;
               r_busy       <= 1'b1;
               r_underrun   <= 1'b0;
               r_sym_cnt    <= '0;
               r_byte_cnt   <= '0;
`ifdef BPSK_TX_CHECKSUM_EN
               r_csum       <= '0;
`endif
            end
            LOAD: r_state <= PREAMBLE;
            PREAMBLE: if (i_mod_next) begin
               if (r_sym_cnt == LAST_PRE) r_state <= SYNC;
               else                       r_mod_data <= ~r_mod_data;
            end
            SYNC: if (i_mod_next && w_ser_last) r_state <= PAYLOAD;
            PAYLOAD: if (i_mod_next && w_ser_last && w_pay_last) begin
`ifdef BPSK_TX_CHECKSUM_EN
               r_state <= CHECKSUM;
`else
               r_state    <= WAIT_DONE;
               r_mod_data <= 1'b0;
`endif
            end
`ifdef BPSK_TX_CHECKSUM_EN
            CHECKSUM: if (i_mod_next && w_ser_last) begin
               r_state    <= WAIT_DONE;
               r_mod_data <= 1'b0;
            end
`endif
            WAIT_DONE: if (i_mod_done) begin
               r_state   <= IDLE;
               r_busy    <= 1'b0;
               r_tx_done <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_in_ready   = r_in_ready;
   assign o_mod_enable = r_mod_enable;
   assign o_mod_data   = r_mod_data;
   assign o_busy       = r_busy;
   assign o_tx_done    = r_tx_done;
   assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_bpsk_tx_sequencer.sv
// Scoreboard bench for bpsk_tx_sequencer; expected symbols are queued at stimulus
// time and checked by a monitor on every mod_next cycle. Honours BPSK_TX_CHECKSUM_EN.
module tb_bpsk_tx_sequencer;

`ifdef BPSK_TX_CHECKSUM_EN
   localparam int FRAME_BITS = 16 + 8 + 32 + 8;
`else
   localparam int FRAME_BITS = 16 + 8 + 32;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready, mod_enable, mod_data, busy, tx_done, underrun;
   logic       mod_next = 1'b0;
   logic       mod_done = 1'b0;

   int   n_total = 0;
   int   n_bad = 0;
   int   en_count = 0;
   int   frames_started = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   bpsk_tx_sequencer dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_tx_start   (tx_start),
      .i_in_data    (in_data),
      .i_in_valid   (in_valid),
      .o_in_ready   (in_ready),
      .o_mod_enable (mod_enable),
      .o_mod_data   (mod_data),
      .i_mod_next   (mod_next),
      .i_mod_done   (mod_done),
      .o_busy       (busy),
      .o_tx_done    (tx_done),
      .o_underrun   (underrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: each mod_next cycle completes the symbol currently on mod_data.
   always @(negedge clk) begin
      if (mod_enable) en_count++;
      if (mod_next) begin
         if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL sym_extra: got %b expected none", mod_data);
         end else begin
            check("symbol", {31'd0, mod_data}, {31'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
   endtask

   task automatic push_preamble_sync();
      for (int i = 0; i < 16; i++) exp_q.push_back((i % 2) == 0);
      push_byte(8'hD3);
   endtask

   task automatic push_frame(input logic [31:0] sent, input logic [7:0] csum);
      push_preamble_sync();
      for (int i = 0; i < 4; i++) push_byte(sent[31-8*i -: 8]);
`ifdef BPSK_TX_CHECKSUM_EN
      push_byte(csum);
`else
      if (csum == 8'h00) exp_q.push_back(1'b0);
`endif
   endtask

   task automatic send_bytes(input logic [31:0] word, input int n);
      int budget;
      for (int i = 0; i < n; i++) begin
         in_data  = word[31-8*i -: 8];
         in_valid = 1'b1;
         budget   = 0;
         @(negedge clk);
         while (!in_ready && budget < 2000) begin
            @(negedge clk);
            budget++;
         end
         if (budget >= 2000) check("byte_accept_timeout", 32'd0, 32'd1);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic start_frame();
      tick();
      tx_start = 1'b1;
      frames_started++;
      tick();
      tx_start = 1'b0;
      @(negedge clk);
      check("load_state", {28'd0, mod_enable, busy, mod_data, underrun}, 32'b1110);
      @(negedge clk);
      check("enable_one_cycle", {30'd0, mod_enable, busy}, 32'b01);
   endtask

   task automatic pulse_symbols(input int n, input bit inject);
      for (int k = 0; k < n; k++) begin
         repeat (7) tick();
         mod_next = 1'b1;
         tx_start = inject && (k == 30);
         tick();
         mod_next = 1'b0;
         tx_start = 1'b0;
      end
   endtask

   task automatic run_frame(input bit inject, input logic exp_underrun);
      start_frame();
      pulse_symbols(FRAME_BITS, inject);
      @(negedge clk);
      check("wait_done", {29'd0, busy, mod_data, tx_done}, 32'b100);
      tick();
      tick();
      mod_done = 1'b1;
      tx_start = inject;
      tick();
      mod_done = 1'b0;
      tx_start = 1'b0;
      @(negedge clk);
      check("tx_done_pulse", {29'd0, tx_done, busy, underrun}, {29'd0, 1'b1, 1'b0, exp_underrun});
      @(negedge clk);
      check("tx_done_single", {31'd0, tx_done}, 32'd0);
      check("enable_count", en_count, frames_started);
   endtask

   initial begin
      // Reset with tx_start held high.
      tx_start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("reset_outputs", {26'd0, in_ready, mod_enable, mod_data, busy, tx_done, underrun}, 32'd0);
      end
      tick();
      reset    = 1'b0;
      tx_start = 1'b0;
      repeat (3) tick();

      // Frame 1: bytes prefetched, no underrun.
      push_frame(32'hA53CFF00, 8'h66);
      fork
         send_bytes(32'hA53CFF00, 4);
         run_frame(1'b0, 1'b0);
      join

      // Frame 2: third and fourth bytes withheld.
      push_frame(32'hA53C0000, 8'h99);
      fork
         send_bytes(32'hA53C0000, 2);
         run_frame(1'b0, 1'b1);
      join
      @(negedge clk);
      check("underrun_sticky", {31'd0, underrun}, 32'd1);

      // Frame 3: stray tx_start mid-payload and on mod_done, underrun cleared by start.
      push_frame(32'h817E55C3, 8'h69);
      fork
         send_bytes(32'h817E55C3, 4);
         run_frame(1'b1, 1'b0);
      join
      begin
         int busy_cycles = 0;
         repeat (20) begin
            @(negedge clk);
            if (busy) busy_cycles++;
         end
         check("no_second_frame", busy_cycles, 0);
         check("enable_count_idle", en_count, frames_started);
      end

      // Frame 4: reset during SYNC after three sync bits.
      push_preamble_sync();
      repeat (5) void'(exp_q.pop_back());
      start_frame();
      pulse_symbols(19, 1'b0);
      @(negedge clk);
      check("pre_reset", {29'd0, busy, mod_data, in_ready}, 32'b111);
      tick();
      reset = 1'b1;
      tick();
      @(negedge clk);
      check("post_reset", {29'd0, busy, mod_data, in_ready}, 32'b000);
      tick();
      reset = 1'b0;
      repeat (2) tick();
      check("sb_after_reset", exp_q.size(), 0);

      // Frame 5: fresh frame after reset.
      push_frame(32'h12345678, 8'h08);
      fork
         send_bytes(32'h12345678, 4);
         run_frame(1'b0, 1'b0);
      join

      repeat (4) tick();
      check("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bpsk_tx_sequencer.md
# bpsk_tx_sequencer

Frame sequencer that drives `signal_modulator`. On a start pulse it pulls payload bytes over a valid/ready interface and presents one symbol bit at a time on the modulator's `data_stream`, advancing on the modulator's `next` pulse. Each frame is preamble, then sync word, then payload, with an optional checksum byte. It sits between the packet source and the modulator and owns the modulator's `enable`.

## Interface
- `PAYLOAD_BYTES`, 4: payload bytes per frame, ≥1.
- `PREAMBLE_BITS`, 16: alternating preamble length, ≥2, even.
- `SYNC_WORD`, 8'hD3: 8-bit sync pattern, sent MSB first.
- `clk` in 1: single clock, same clock as the modulator.
- `reset` in 1: synchronous, active-high.
- `tx_start` in 1: one-cycle start request; ignored unless IDLE.
- `in_data` in 8: payload byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `mod_enable` out 1: to modulator `enable`.
- `mod_data` out 1: to modulator `data_stream`.
- `mod_next` in 1: modulator `next`; a high cycle means the current symbol is complete.
- `mod_done` in 1: modulator `done`.
- `busy` out 1: high in every state except IDLE.
- `tx_done` out 1: one-cycle pulse at frame end.
- `underrun` out 1: sticky; set when a payload byte was missing at a byte boundary; cleared by `reset` or an accepted `tx_start`.

## Operation
- States: IDLE, LOAD, PREAMBLE, SYNC, PAYLOAD, CHECKSUM (only with the macro), WAIT_DONE.
- IDLE → LOAD on `tx_start`.
- LOAD lasts one cycle:
  - `mod_enable`=1 for that cycle only; the modulator latches it.
  - `mod_data`=1, the first preamble bit.
  - Next state is PREAMBLE.
- Preamble is 1,0,1,0,… for PREAMBLE_BITS symbols. SYNC sends 8 bits of SYNC_WORD, MSB first.
- PAYLOAD sends PAYLOAD_BYTES bytes, each MSB first.
- Byte buffering:
  - One-byte holding register. `in_ready` = holding register empty AND state ∈ {LOAD, PREAMBLE, SYNC, PAYLOAD} AND payload bytes fetched < PAYLOAD_BYTES.
  - At each payload byte boundary the holding register moves into the shift register.
  - If the holding register is empty at a boundary, set `underrun` and send 0x00 for that byte. The frame continues because the modulator cannot be stopped once enabled.
- Symbol advance: each cycle with `mod_next`=1 and state ∈ {PREAMBLE..CHECKSUM}, the symbol counter increments and `mod_data` is updated.
- The symbol after the last one is counted → WAIT_DONE, with `mod_data`=0.
- WAIT_DONE → IDLE when `mod_done`=1; `tx_done` pulses on the IDLE entry cycle.
- `mod_next` in IDLE, LOAD or WAIT_DONE is ignored.
- Frame length TX_FRAME_BITS = PREAMBLE_BITS + 8 + 8·PAYLOAD_BYTES (+8 with checksum). This must equal PACKET_WIDTH_OVERHEAD in parameters.svh. Mismatch is a configuration error checked by an elaboration assertion.

## Timing
- Reset values: `in_ready`=0, `mod_enable`=0, `mod_data`=0, `busy`=0, `tx_done`=0, `underrun`=0; state=IDLE; all counters and the checksum = 0.
- All outputs are registered.
- `tx_start` at cycle 0 → LOAD at cycle 1 with `mod_enable`=1 and `busy`=1.
- `mod_next` high at cycle n → new `mod_data` visible at cycle n+1.
- `tx_start` while not IDLE is dropped, including on the cycle `mod_done` arrives.
- Simultaneous byte accept and byte-boundary transfer: the transfer uses the old holding contents, and the accepted byte enters the emptied register. No loss, no duplication.
- `reset` mid-frame → all outputs and state return to reset values on the next edge.
- The modulator has no reset, so the system must reset both blocks together or wait for `mod_done`.

## Configuration
- `BPSK_TX_CHECKSUM_EN` defined: after the payload, a CHECKSUM state sends the XOR of all transmitted payload bytes, MSB first. Substituted 0x00 bytes are included in the XOR.
- `BPSK_TX_CHECKSUM_EN` undefined: the CHECKSUM state, checksum register and the extra 8 bits do not exist; PAYLOAD → WAIT_DONE directly.

## Structure
- Package `bpsk_tx_pkg` holds:
  - state enum `tx_state_t`;
  - `SYNC_WORD_DEFAULT`;
  - function `tx_frame_bits(preamble, payload)` that honours the macro.
- Sub-module `tx_bit_serializer`:
  - 8-bit MSB-first shift register plus 3-bit bit counter;
  - `load`/`shift` inputs, `bit_out` and `last_bit` outputs;
  - used for SYNC, PAYLOAD and CHECKSUM.

## Test plan
- Reset with `tx_start` held high → all outputs 0 and state IDLE until `reset` falls; `tx_start` then produces `mod_enable` exactly one cycle.
- Bytes A5,3C,FF,00 prefetched, `mod_next` every 8 cycles → `mod_data` sequence 1010…(16), D3, A5, 3C, FF, 00, then (with macro) checksum 66. `tx_done` pulses one cycle after `mod_done`; `underrun`=0.
- Byte 3 withheld → bytes 3 and 4 sent as 0x00 (byte 4 blocked by `in_ready` stall is tolerable), `underrun`=1; a later `tx_start` clears it.
- `tx_start` pulsed mid-PAYLOAD and on the `mod_done` cycle → ignored; exactly one frame sent.
- `reset` asserted during SYNC → next cycle `busy`=0, `mod_data`=0, `in_ready`=0; fresh frame afterwards starts with preamble bit 1.
